// File: rtl/fp32_mul_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
package fp32_mul_pkg;

   typedef enum logic [2:0] {IDLE, NORM, MUL, RND, DONE} state_t;

   localparam int unsigned FP_BIAS    = 127;
   localparam int unsigned FP_EXP_MAX = 255;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] FP_PINF    = 32'h7F80_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   // Significand with the implicit bit restored (0 for subnormals).
   function automatic logic [23:0] fp32_man(input fp32_t f);
      return {|f.exp, f.frac};
   endfunction

endpackage

// File: rtl/fp32_lzc24.sv
// 24-bit leading-zero counter; also returns the mantissa left-justified.
// An all-zero input reports 23 (callers treat a zero mantissa separately).
module fp32_lzc24 (
   input  logic [23:0] man_i,
   output logic [4:0]  lz_o,
   output logic [23:0] man_o
);

   // Priority search from the MSB down.
   always_comb begin
      logic found;
      found = 1'b0;
      lz_o  = 5'd23;
      for (int i = 23; i >= 0; i--) begin
         if (!found && man_i[i]) begin
            lz_o  = 5'(23 - i);
            found = 1'b1;
         end
      end
      man_o = man_i << lz_o;
   end

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle binary32 multiplier: NORM -> iterative shift-add MUL -> RND (RNE) -> DONE.
// Optional macro FP32_MUL_SPECIAL_EN: NaN/Inf operands bypass MUL/RND straight to DONE.
module fp32_mul_seq
   import fp32_mul_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] mul1,
   input  logic [31:0] mul2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_ovf,
   output logic        flag_uf,
   output logic        flag_inx
);

   localparam int unsigned MulCycles = 24 / BITS_PER_CYCLE;

   state_t             state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   fp32_t              a_q, a_d, b_q, b_d;
   logic               sign_q, sign_d, zero_q, zero_d;
   logic signed [9:0]  exp_q, exp_d;
   logic [47:0]        acc_q, acc_d, mcand_q, mcand_d;
   logic [23:0]        mplier_q, mplier_d;
   logic [31:0]        result_q, result_d;
   logic               ovf_q, ovf_d, uf_q, uf_d, inx_q, inx_d, out_valid_q, out_valid_d;

   logic [4:0]         lz_a, lz_b;
   logic [23:0]        nman_a, nman_b;
   logic [7:0]         eff_a, eff_b;
   logic signed [9:0]  e_norm, re;
   logic [23:0]        rm;
   logic [24:0]        rsum;
   logic               g, s;

   fp32_lzc24 u_lzc_a (.man_i(fp32_man(a_q)), .lz_o(lz_a), .man_o(nman_a));
   fp32_lzc24 u_lzc_b (.man_i(fp32_man(b_q)), .lz_o(lz_b), .man_o(nman_b));

   assign eff_a  = (a_q.exp == 8'd0) ? 8'd1 : a_q.exp;
   assign eff_b  = (b_q.exp == 8'd0) ? 8'd1 : b_q.exp;
   assign e_norm = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - $signed(10'(FP_BIAS))
                   - $signed({5'b0, lz_a}) - $signed({5'b0, lz_b});

   // Next-state: sequencing, accumulator, rounding and result packing.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      sign_d      = sign_q;
      zero_d      = zero_q;
      exp_d       = exp_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      uf_d        = uf_q;
      inx_d       = inx_q;
      out_valid_d = 1'b0;
      re          = exp_q;
      rm          = 24'd0;
      rsum        = 25'd0;
      g           = 1'b0;
      s           = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = mul1;
               b_d     = mul2;
               ovf_d   = 1'b0;
               uf_d    = 1'b0;
               inx_d   = 1'b0;
               state_d = NORM;
            end
         end
         NORM: begin
            sign_d   = a_q.sign ^ b_q.sign;
            exp_d    = e_norm;
            zero_d   = (fp32_man(a_q) == 24'd0) || (fp32_man(b_q) == 24'd0);
            mcand_d  = {24'd0, nman_a};
            mplier_d = nman_b;
            acc_d    = 48'd0;
            cnt_d    = 5'd0;
            state_d  = MUL;
`ifdef FP32_MUL_SPECIAL_EN
            begin
               logic nan_a, nan_b, inf_a, inf_b, z_a, z_b;
               nan_a = (a_q.exp == 8'(FP_EXP_MAX)) && (a_q.frac != 23'd0);
               nan_b = (b_q.exp == 8'(FP_EXP_MAX)) && (b_q.frac != 23'd0);
               inf_a = (a_q.exp == 8'(FP_EXP_MAX)) && (a_q.frac == 23'd0);
               inf_b = (b_q.exp == 8'(FP_EXP_MAX)) && (b_q.frac == 23'd0);
               z_a   = fp32_man(a_q) == 24'd0;
               z_b   = fp32_man(b_q) == 24'd0;
               if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) begin
                  result_d = FP_QNAN;
                  state_d  = DONE;
               end else if (inf_a || inf_b) begin
                  result_d = FP_PINF | {a_q.sign ^ b_q.sign, 31'd0};
                  state_d  = DONE;
               end
            end
`endif
         end
         MUL: begin
            for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
               if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
            end
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(MulCycles - 1)) state_d = RND;
         end
         RND: begin
            if (acc_q[47]) begin
               rm = acc_q[47:24];
               g  = acc_q[23];
               s  = |acc_q[22:0];
               re = exp_q + 10'sd1;
            end else begin
               rm = acc_q[46:23];
               g  = acc_q[22];
               s  = |acc_q[21:0];
            end
            rsum = {1'b0, rm} + 25'(g & (s | rm[0]));
            // Rounding carry-out: mantissa becomes 1.0, exponent bumps.
            if (rsum[24]) begin
               rm = 24'h80_0000;
               re = re + 10'sd1;
            end else begin
               rm = rsum[23:0];
            end
            if (zero_q) begin
               result_d = {sign_q, 31'd0};
            end else if (re >= $signed(10'(FP_EXP_MAX))) begin
               result_d = FP_PINF | {sign_q, 31'd0};
               ovf_d    = 1'b1;
               inx_d    = 1'b1;
            end else if (re <= 10'sd0) begin
               result_d = {sign_q, 31'd0};
               uf_d     = 1'b1;
               inx_d    = 1'b1;
            end else begin
               result_d = {sign_q, re[7:0], rm[22:0]};
               inx_d    = g | s;
            end
            state_d = DONE;
         end
         DONE: begin
            // out_valid is registered one cycle after entering DONE.
            if (out_valid_q && out_ready) state_d = IDLE;
            else out_valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         zero_q      <= 1'b0;
         exp_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         uf_q        <= 1'b0;
         inx_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sign_q      <= sign_d;
         zero_q      <= zero_d;
         exp_q       <= exp_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         uf_q        <= uf_d;
         inx_q       <= inx_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag_ovf  = ovf_q;
   assign flag_uf   = uf_q;
   assign flag_inx  = inx_q;

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Directed scoreboard bench for fp32_mul_seq (BITS_PER_CYCLE=1 and 4 instances).
// Honours FP32_MUL_SPECIAL_EN when defined.
module tb_fp32_mul_seq;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flags;   // {ovf, uf, inx}
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_valid4 = 1'b0;
   logic        out_ready = 1'b1, out_ready4 = 1'b1;
   logic [31:0] mul1 = '0, mul2 = '0, mul1_4 = '0, mul2_4 = '0;
   logic        in_ready, out_valid, flag_ovf, flag_uf, flag_inx;
   logic        in_ready4, out_valid4, flag_ovf4, flag_uf4, flag_inx4;
   logic [31:0] result, result4;

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   fp32_mul_seq #(.BITS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mul1(mul1), .mul2(mul2), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_ovf(flag_ovf), .flag_uf(flag_uf), .flag_inx(flag_inx)
   );

   fp32_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .mul1(mul1_4), .mul2(mul2_4), .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .flag_ovf(flag_ovf4), .flag_uf(flag_uf4), .flag_inx(flag_inx4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One full transaction on the selected instance with out_ready held high.
   task automatic run_op(input bit w4, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [2:0] fl, input int lat,
                         input string tag);
      int   n;
      bit   seen;
      exp_t e;
      @(negedge clk);
      check({tag, ":in_ready"}, {31'd0, w4 ? in_ready4 : in_ready}, 32'd1);
      if (w4) begin in_valid4 = 1'b1; mul1_4 = a; mul2_4 = b; end
      else begin in_valid = 1'b1; mul1 = a; mul2 = b; end
      sb.push_back('{res, fl});
      @(posedge clk);
      #1;
      // Operands must be captured; scramble the bus afterwards.
      if (w4) begin in_valid4 = 1'b0; mul1_4 = $urandom; mul2_4 = $urandom; end
      else begin in_valid = 1'b0; mul1 = $urandom; mul2 = $urandom; end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (w4 ? out_valid4 : out_valid) seen = 1'b1;
      end
      check({tag, ":latency"}, 32'(n), 32'(lat));
      e = sb.pop_front();
      if (w4) begin
         check({tag, ":result"}, result4, e.res);
         check({tag, ":flags"}, {29'd0, flag_ovf4, flag_uf4, flag_inx4}, {29'd0, e.flags});
      end else begin
         check({tag, ":result"}, result, e.res);
         check({tag, ":flags"}, {29'd0, flag_ovf, flag_uf, flag_inx}, {29'd0, e.flags});
      end
      @(posedge clk);
      #1;
      check({tag, ":out_valid_drop"}, {31'd0, w4 ? out_valid4 : out_valid}, 32'd0);
   endtask

   initial begin
      exp_t e;
      int   n;
      int   extra;
      bit   seen;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst:in_ready", {31'd0, in_ready}, 32'd1);
      check("rst:out_valid", {31'd0, out_valid}, 32'd0);
      check("rst:result", result, 32'd0);
      check("rst:flags", {29'd0, flag_ovf, flag_uf, flag_inx}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 27, "one_x_one");
      run_op(1'b0, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 3'b000, 27, "three_x_m2");
      run_op(1'b0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b001, 27, "inexact");
      run_op(1'b0, 32'h0040_0000, 32'h4B00_0000, 32'h0B80_0000, 3'b000, 27, "subnormal");
      run_op(1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b011, 27, "underflow");
      run_op(1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b101, 27, "overflow");
      run_op(1'b0, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3'b000, 27, "neg_zero");
`ifdef FP32_MUL_SPECIAL_EN
      run_op(1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 2, "nan_in");
      run_op(1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b000, 2, "inf_x_zero");
      run_op(1'b0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 2, "inf_x_fin");
`else
      run_op(1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b101, 27, "exp255_ovf");
      run_op(1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 3'b000, 27, "exp255_x_zero");
`endif

      // Backpressure: hold out_ready low for 5 cycles while offering a second op.
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      mul1 = 32'h4040_0000;
      mul2 = 32'hC000_0000;
      sb.push_back('{32'hC0C0_0000, 3'b000});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1'b1;
      end
      check("bp:valid_seen", {31'd0, seen}, 32'd1);
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         mul1 = 32'h3F80_0000;
         mul2 = 32'h4000_0000;
         @(posedge clk);
         @(negedge clk);
         check("bp:result", result, e.res);
         check("bp:flags", {29'd0, flag_ovf, flag_uf, flag_inx}, {29'd0, e.flags});
         check("bp:in_ready", {31'd0, in_ready}, 32'd0);
         check("bp:out_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp:released", {31'd0, out_valid}, 32'd0);
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("bp:no_second_op", 32'(extra), 32'd0);

      // Reset during MUL cycle 10 aborts the operation.
      @(negedge clk);
      in_valid = 1'b1;
      mul1 = 32'h4040_0000;
      mul2 = 32'h4040_0000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort:out_valid", {31'd0, out_valid}, 32'd0);
      check("abort:in_ready", {31'd0, in_ready}, 32'd1);
      check("abort:result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 27, "after_abort");

      // Four bits per cycle.
      run_op(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 9, "b4_one");
      run_op(1'b1, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b001, 9, "b4_inexact");
      run_op(1'b1, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 3'b000, 9, "b4_three_x_m2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
